// File: rtl/tmds_dc_balance_if.sv
// rtl/tmds_dc_balance_if.sv - per-channel q_m in / TMDS symbol out bundle
interface tmds_dc_balance_if;
  logic [8:0]        q_m_in;
  logic              ve_in;
  logic [1:0]        ctrl_in;
  logic [9:0]        tmds_out;
  logic signed [4:0] tally_out;

  modport master (
    output q_m_in, ve_in, ctrl_in,
    input  tmds_out, tally_out
  );

  modport slave (
    input  q_m_in, ve_in, ctrl_in,
    output tmds_out, tally_out
  );
endinterface

// File: rtl/tmds_dc_balance.sv
// rtl/tmds_dc_balance.sv - TMDS DC-balance stage with running disparity tally
module tmds_dc_balance (
  input logic               clk_in,
  input logic               rst_in_n,
  tmds_dc_balance_if.slave  bus
);

  logic [3:0]        n1;
  logic signed [4:0] n1_s;
  logic signed [4:0] n0_s;
  logic signed [4:0] two_q8;
  logic signed [4:0] two_nq8;
  logic signed [4:0] tally;
  logic signed [4:0] tally_next;
  logic [9:0]        tmds_q;
  logic [9:0]        tmds_next;
  logic              q8;

  assign q8 = bus.q_m_in[8];

  always_comb begin
    n1 = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n1 = n1 + {3'b000, bus.q_m_in[i]};
    end
  end

  assign n1_s    = $signed({1'b0, n1});
  assign n0_s    = 5'sd8 - n1_s;
  assign two_q8  = $signed({3'b000, q8, 1'b0});
  assign two_nq8 = $signed({3'b000, ~q8, 1'b0});

  // Each branch adds the disparity of the symbol it emits, keeping tally in -10..+10.
  always_comb begin
    tmds_next  = 10'b0;
    tally_next = tally;
    if (!bus.ve_in) begin
      tally_next = 5'sd0;
      case (bus.ctrl_in)
        2'b00:   tmds_next = 10'b1101010100;
        2'b01:   tmds_next = 10'b0010101011;
        2'b10:   tmds_next = 10'b0101010100;
        default: tmds_next = 10'b1010101011;
      endcase
    end else if (tally == 5'sd0 || n1_s == n0_s) begin
      tmds_next  = {~q8, q8, q8 ? bus.q_m_in[7:0] : ~bus.q_m_in[7:0]};
      tally_next = q8 ? tally + (n1_s - n0_s) : tally + (n0_s - n1_s);
    end else if ((tally > 5'sd0 && n1_s > n0_s) || (tally < 5'sd0 && n0_s > n1_s)) begin
      tmds_next  = {1'b1, q8, ~bus.q_m_in[7:0]};
      tally_next = tally + two_q8 + (n0_s - n1_s);
    end else begin
      tmds_next  = {1'b0, q8, bus.q_m_in[7:0]};
      tally_next = tally - two_nq8 + (n1_s - n0_s);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      tmds_q <= 10'b0;
      tally  <= 5'sd0;
    end else begin
      tmds_q <= tmds_next;
      tally  <= tally_next;
    end
  end

  assign bus.tmds_out  = tmds_q;
  assign bus.tally_out = tally;

endmodule

// File: tb/tb_tmds_dc_balance.sv
// tb/tb_tmds_dc_balance.sv - self-checking bench for tmds_dc_balance
module tb_tmds_dc_balance;

  logic clk_in = 1'b0;
  logic rst_in_n;

  tmds_dc_balance_if bus ();

  tmds_dc_balance dut (
    .clk_in   (clk_in),
    .rst_in_n (rst_in_n),
    .bus      (bus)
  );

  always #5 clk_in = ~clk_in;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
  endtask

  // Reference: the tally accumulates the disparity of every emitted data symbol.
  int         m_tally;
  logic [9:0] m_tmds;
  logic       m_inv;
  int         m_n1;

  always @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      m_tally = 0;
      m_tmds  = 10'b0;
    end else if (!bus.ve_in) begin
      m_tally = 0;
      case (bus.ctrl_in)
        2'b00:   m_tmds = 10'b1101010100;
        2'b01:   m_tmds = 10'b0010101011;
        2'b10:   m_tmds = 10'b0101010100;
        default: m_tmds = 10'b1010101011;
      endcase
    end else begin
      m_n1 = $countones(bus.q_m_in[7:0]);
      if (m_tally == 0 || m_n1 == 4) m_inv = !bus.q_m_in[8];
      else m_inv = (m_tally > 0 && m_n1 > 4) || (m_tally < 0 && m_n1 < 4);
      m_tmds  = {m_inv, bus.q_m_in[8], m_inv ? ~bus.q_m_in[7:0] : bus.q_m_in[7:0]};
      m_tally = m_tally + 2 * $countones(m_tmds) - 10;
    end
  end

  always @(negedge clk_in) begin
    check("model_tmds",  {22'b0, bus.tmds_out}, {22'b0, m_tmds});
    check("model_tally", $signed(bus.tally_out), m_tally);
  end

  task automatic drive(input logic [8:0] q, input logic ve, input logic [1:0] ctrl);
    bus.q_m_in  = q;
    bus.ve_in   = ve;
    bus.ctrl_in = ctrl;
    @(posedge clk_in);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [9:0] t, input int tl);
    check({name, "_tmds"},  {22'b0, bus.tmds_out}, {22'b0, t});
    check({name, "_tally"}, $signed(bus.tally_out), tl);
  endtask

  logic [8:0] vec [0:11] = '{9'h100, 9'h0FF, 9'h1F0, 9'h03C, 9'h1FE, 9'h001,
                             9'h17F, 9'h080, 9'h0AA, 9'h155, 9'h1FF, 9'h000};

  initial begin
    rst_in_n    = 1'b0;
    bus.q_m_in  = 9'h000;
    bus.ve_in   = 1'b0;
    bus.ctrl_in = 2'b00;

    for (int i = 0; i < 6; i++) begin
      bus.q_m_in  = 9'(i * 83 + 5);
      bus.ve_in   = i[0];
      bus.ctrl_in = 2'(i);
      #3;
      expect_out("reset_hold", 10'b0, 0);
      #4;
    end
    @(negedge clk_in);
    rst_in_n = 1'b1;

    drive(9'h000, 1'b0, 2'b00); expect_out("tok00", 10'b1101010100, 0);
    drive(9'h000, 1'b0, 2'b01); expect_out("tok01", 10'b0010101011, 0);
    drive(9'h000, 1'b0, 2'b10); expect_out("tok10", 10'b0101010100, 0);
    drive(9'h000, 1'b0, 2'b11); expect_out("tok11", 10'b1010101011, 0);

    drive(9'h100, 1'b1, 2'b00); expect_out("disp1", 10'b0100000000, -8);
    drive(9'h100, 1'b1, 2'b00); expect_out("disp2", 10'b1111111111, 2);
    drive(9'h100, 1'b1, 2'b00); expect_out("disp3", 10'b0100000000, -6);

    drive(9'h000, 1'b0, 2'b00);
    drive(9'h00F, 1'b1, 2'b00); expect_out("balanced", 10'b1011110000, 0);

    drive(9'h000, 1'b0, 2'b00);
    drive(9'h100, 1'b1, 2'b00); expect_out("pre_rst", 10'b0100000000, -8);
    #2 rst_in_n = 1'b0;
    #1 expect_out("async_rst", 10'b0, 0);
    #1 rst_in_n = 1'b1;
    drive(9'h100, 1'b1, 2'b00); expect_out("post_rst", 10'b0100000000, -8);

    drive(9'h100, 1'b1, 2'b00); expect_out("blank_a", 10'b1111111111, 2);
    drive(9'h100, 1'b1, 2'b00); expect_out("blank_b", 10'b0100000000, -6);
    drive(9'h000, 1'b0, 2'b11); expect_out("blank_tok", 10'b1010101011, 0);
    drive(9'h100, 1'b1, 2'b00); expect_out("blank_resume", 10'b0100000000, -8);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 12; i++) begin
        drive(vec[(i + r * 5) % 12], 1'b1, 2'b00);
      end
      drive(9'h000, 1'b0, 2'(r));
    end
    for (int i = 0; i < 12; i++) begin
      drive(vec[11 - i], 1'b1, 2'b00);
    end

    @(negedge clk_in);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
